// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller: FSM encodings,
// EX operand forward-select codes and the common register-match test.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } hazardState_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // $0 is hard-wired zero, so a write to it never produces a dependency.
  function automatic logic regHit(input logic regWrite, input logic [4:0] dest,
                                  input logic [4:0] src);
    return regWrite && (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding select; the younger MEM result wins over WB.
module forward_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] exRs,
  input  logic [4:0] exRt,
  input  logic [4:0] memWriteSrc,
  input  logic       memRegWrite,
  input  logic [4:0] wbWriteSrc,
  input  logic       wbRegWrite,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB
);

  always_comb begin
    forwardA = FWD_REG;
    forwardB = FWD_REG;
    if (regHit(memRegWrite, memWriteSrc, exRs))     forwardA = FWD_MEM;
    else if (regHit(wbRegWrite, wbWriteSrc, exRs))  forwardA = FWD_WB;
    if (regHit(memRegWrite, memWriteSrc, exRt))     forwardB = FWD_MEM;
    else if (regHit(wbRegWrite, wbWriteSrc, exRt))  forwardB = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with a req/ready
// data-memory handshake, saturating stall counter and sticky DM timeout flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; branch, load-use and memory stalls detected
//   MEM_WAIT | pipe frozen waiting for DMReady or the timeout terminal count
//   BR_FLUSH | IF/ID still being flushed for the remaining branch penalty
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BRANCH_PENALTY = 2,
  parameter int DM_TIMEOUT     = 15,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic [4:0]       EX_writeSrc,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_writeSrc,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemAccess,
  input  logic [4:0]       WB_writeSrc,
  input  logic             WB_RegWrite,
  input  logic             BranchTaken,
  input  logic             DMReady,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Bubble,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             DMReq,
  output logic             DMError,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int WT = $clog2(DM_TIMEOUT + 1);
  localparam int FW = $clog2(BRANCH_PENALTY + 1);

  hazardState_t   state, stateNext;
  logic [WT-1:0]  waitCnt, waitNext;
  logic [FW-1:0]  flushCnt, flushNext;
  logic           memBusy, waitTc, frozen, loadUse, timeoutHit;
  logic [1:0]     fwdA, fwdB;

  forward_unit uForward (
    .exRs        (EX_rs),
    .exRt        (EX_rt),
    .memWriteSrc (MEM_writeSrc),
    .memRegWrite (MEM_RegWrite),
    .wbWriteSrc  (WB_writeSrc),
    .wbRegWrite  (WB_RegWrite),
    .forwardA    (fwdA),
    .forwardB    (fwdB)
  );

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    ForwardA      = fwdA;
    ForwardB      = fwdB;
    stateNext     = state;
    waitNext      = waitCnt;
    flushNext     = flushCnt;
    timeoutHit    = 1'b0;

    memBusy = (state == MEM_WAIT) || MEM_MemAccess;
    DMReq   = memBusy;
    waitTc  = (state == MEM_WAIT) && (waitCnt == '0);
    frozen  = memBusy && !DMReady && !waitTc;
    loadUse = EX_MemRead && (EX_writeSrc != 5'd0) &&
              ((EX_writeSrc == ID_rs) || (EX_writeSrc == ID_rt));

    if (frozen) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
      stateNext     = MEM_WAIT;
      waitNext      = (state == MEM_WAIT) ? waitCnt - WT'(1) : WT'(DM_TIMEOUT - 1);
    end else begin
      // A flush interrupted by a memory stall resumes here on release.
      timeoutHit = waitTc && !DMReady;
      if (BranchTaken) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        flushNext   = FW'(BRANCH_PENALTY - 1);
      end else if (flushCnt != '0) begin
        IF_ID_Flush = 1'b1;
        flushNext   = flushCnt - FW'(1);
      end else if (loadUse) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
      stateNext = (flushNext != '0) ? BR_FLUSH : RUN;
    end

    if (Reset) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      MEM_WB_Bubble = 1'b1;
      DMReq         = 1'b0;
      ForwardA      = FWD_REG;
      ForwardB      = FWD_REG;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      flushCnt    <= '0;
      DMError     <= 1'b0;
      StallCycles <= '0;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitNext;
      flushCnt <= flushNext;
      if (timeoutHit) DMError <= 1'b1;
      if (!PCWrite && (StallCycles != '1)) StallCycles <= StallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table vectors plus hand-written
// multi-cycle sequences, with expected outputs queued at drive time.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  ID_rs = '0, ID_rt = '0, EX_rs = '0, EX_rt = '0;
  logic [4:0]  EX_writeSrc = '0, MEM_writeSrc = '0, WB_writeSrc = '0;
  logic        EX_MemRead = 0, MEM_RegWrite = 0, MEM_MemAccess = 0, WB_RegWrite = 0;
  logic        BranchTaken = 0, DMReady = 0;
  logic        PCWrite, IF_ID_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble;
  logic [1:0]  ForwardA, ForwardB;
  logic        DMReq, DMError;
  logic [15:0] StallCycles;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.BRANCH_PENALTY(2), .DM_TIMEOUT(15), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_rs(EX_rs), .EX_rt(EX_rt),
    .EX_writeSrc(EX_writeSrc), .EX_MemRead(EX_MemRead), .MEM_writeSrc(MEM_writeSrc),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemAccess(MEM_MemAccess), .WB_writeSrc(WB_writeSrc),
    .WB_RegWrite(WB_RegWrite), .BranchTaken(BranchTaken), .DMReady(DMReady),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .EX_MEM_Write(EX_MEM_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .MEM_WB_Bubble(MEM_WB_Bubble),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .DMReq(DMReq), .DMError(DMError),
    .StallCycles(StallCycles)
  );

  // Expected-output bits: PCWrite IF_ID_Write EX_MEM_Write IF_ID_Flush ID_EX_Flush
  // MEM_WB_Bubble ForwardA[1:0] ForwardB[1:0] DMReq DMError
  localparam logic [11:0] PC = 12'h800, IFIDW = 12'h400, EXMEMW = 12'h200;
  localparam logic [11:0] IFF = 12'h100, IEF = 12'h080, BUB = 12'h040;
  localparam logic [11:0] FA_MEM = 12'h020, FA_WB = 12'h010, FB_MEM = 12'h008, FB_WB = 12'h004;
  localparam logic [11:0] REQ = 12'h002, ERR = 12'h001;
  localparam logic [11:0] E_RUN = PC | IFIDW | EXMEMW;
  localparam logic [11:0] E_RST = IFF | IEF | BUB;
  localparam logic [11:0] E_FRZ = BUB | REQ;
  localparam logic [11:0] E_LU  = EXMEMW | IEF;
  localparam logic [11:0] E_BR  = E_RUN | IFF | IEF;
  localparam logic [11:0] E_BRF = E_RUN | IFF;

  // Input flag bits: Reset BranchTaken DMReady MEM_MemAccess EX_MemRead MEM_RegWrite WB_RegWrite
  localparam logic [6:0] F_RST = 7'h40, F_BR = 7'h20, F_RDY = 7'h10, F_ACC = 7'h08;
  localparam logic [6:0] F_LD = 7'h04, F_MRW = 7'h02, F_WRW = 7'h01;

  typedef struct {
    string      name;
    logic [6:0] flg;
    logic [4:0] idRs, idRt, exRs, exRt, exWs, memWs, wbWs;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] expQ[$];
  string       nameQ[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] expStall = '0;
  logic        lastRst = 1'b1;
  logic        lastPc = 1'b0;

  function automatic vec_t mk(input string n, input logic [6:0] f,
                              input logic [4:0] idRs, input logic [4:0] idRt,
                              input logic [4:0] exRs, input logic [4:0] exRt,
                              input logic [4:0] exWs, input logic [4:0] memWs,
                              input logic [4:0] wbWs, input logic [11:0] e);
    vec_t v;
    v.name = n; v.flg = f; v.idRs = idRs; v.idRt = idRt; v.exRs = exRs; v.exRt = exRt;
    v.exWs = exWs; v.memWs = memWs; v.wbWs = wbWs; v.exp = e;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic [11:0] e, got;
    string n;
    @(posedge CLK);
    if (lastRst) expStall = '0;
    else if (!lastPc && expStall != 16'hFFFF) expStall = expStall + 16'd1;
    #1;
    {Reset, BranchTaken, DMReady, MEM_MemAccess, EX_MemRead, MEM_RegWrite, WB_RegWrite} = v.flg;
    ID_rs = v.idRs; ID_rt = v.idRt; EX_rs = v.exRs; EX_rt = v.exRt;
    EX_writeSrc = v.exWs; MEM_writeSrc = v.memWs; WB_writeSrc = v.wbWs;
    expQ.push_back(v.exp);
    nameQ.push_back(v.name);
    @(negedge CLK);
    e = expQ.pop_front();
    n = nameQ.pop_front();
    got = {PCWrite, IF_ID_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble,
           ForwardA, ForwardB, DMReq, DMError};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s outputs: got=%b expected=%b", n, got, e);
    end
    checks++;
    if (StallCycles !== expStall) begin
      errors++;
      $display("FAIL %s StallCycles: got=%0d expected=%0d", n, StallCycles, expStall);
    end
    lastRst = v.flg[6];
    lastPc  = v.exp[11];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-cycle table: reset, forwarding and load-use patterns.
    vecs.push_back(mk("reset0",     F_RST | F_MRW,  0, 0, 5, 0, 0, 5, 0, E_RST));
    vecs.push_back(mk("reset1",     F_RST,          0, 0, 0, 0, 0, 0, 0, E_RST));
    vecs.push_back(mk("idle",       7'h00,          1, 2, 3, 4, 0, 0, 0, E_RUN));
    vecs.push_back(mk("fwdA_mem",   F_MRW,          0, 0, 5, 0, 0, 5, 0, E_RUN | FA_MEM));
    vecs.push_back(mk("fwdA_wb",    F_WRW,          0, 0, 7, 0, 0, 0, 7, E_RUN | FA_WB));
    vecs.push_back(mk("fwdA_both",  F_MRW | F_WRW,  0, 0, 9, 0, 0, 9, 9, E_RUN | FA_MEM));
    vecs.push_back(mk("fwd_r0",     F_MRW | F_WRW,  0, 0, 0, 0, 0, 0, 0, E_RUN));
    vecs.push_back(mk("fwdAB",      F_MRW | F_WRW,  0, 0, 6, 4, 0, 6, 4, E_RUN | FA_MEM | FB_WB));
    vecs.push_back(mk("fwdB_mem",   F_MRW,          0, 0, 1, 12, 0, 12, 0, E_RUN | FB_MEM));
    vecs.push_back(mk("fwd_noRW",   7'h00,          0, 0, 5, 5, 0, 5, 5, E_RUN));
    vecs.push_back(mk("lu_rs",      F_LD,           3, 0, 0, 0, 3, 0, 0, E_LU));
    vecs.push_back(mk("lu_after",   7'h00,          3, 0, 0, 0, 0, 0, 0, E_RUN));
    vecs.push_back(mk("lu_rt",      F_LD,           1, 8, 0, 0, 8, 0, 0, E_LU));
    vecs.push_back(mk("lu_r0",      F_LD,           0, 0, 0, 0, 0, 0, 0, E_RUN));
    vecs.push_back(mk("lu_nomatch", F_LD,           1, 2, 0, 0, 3, 0, 0, E_RUN));
    vecs.push_back(mk("mem_ready",  F_ACC | F_RDY,  0, 0, 0, 0, 0, 0, 0, E_RUN | REQ));
    foreach (vecs[i]) step(vecs[i]);

    // Three-cycle DM wait; a branch seen while frozen is ignored.
    step(mk("wait_c1", F_ACC,         0, 0, 0, 0, 0, 0, 0, E_FRZ));
    step(mk("wait_c2", F_ACC | F_BR,  0, 0, 0, 0, 0, 0, 0, E_FRZ));
    step(mk("wait_c3", F_ACC,         0, 0, 0, 0, 0, 0, 0, E_FRZ));
    step(mk("wait_rel", F_ACC | F_RDY, 0, 0, 0, 0, 0, 0, 0, E_RUN | REQ));
    step(mk("wait_post", 7'h00,       0, 0, 0, 0, 0, 0, 0, E_RUN));

    // Branch penalty 2, then branch colliding with load-use.
    step(mk("br_c1", F_BR,  0, 0, 0, 0, 0, 0, 0, E_BR));
    step(mk("br_c2", 7'h00, 0, 0, 0, 0, 0, 0, 0, E_BRF));
    step(mk("br_c3", 7'h00, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    step(mk("br_lu_c1", F_BR | F_LD, 3, 0, 0, 0, 3, 0, 0, E_BR));
    step(mk("br_lu_c2", 7'h00,       0, 0, 0, 0, 0, 0, 0, E_BRF));
    step(mk("br_lu_c3", 7'h00,       0, 0, 0, 0, 0, 0, 0, E_RUN));

    // Memory stall arriving during the branch flush; flush resumes at release.
    step(mk("brm_c1", F_BR,          0, 0, 0, 0, 0, 0, 0, E_BR));
    step(mk("brm_c2", F_ACC,         0, 0, 0, 0, 0, 0, 0, E_FRZ));
    step(mk("brm_c3", F_ACC | F_RDY, 0, 0, 0, 0, 0, 0, 0, E_BRF | REQ));
    step(mk("brm_c4", 7'h00,         0, 0, 0, 0, 0, 0, 0, E_RUN));

    // DMReady never arrives: 15 frozen cycles, release, sticky DMError.
    for (int i = 0; i < 15; i++)
      step(mk("tmo_wait", F_ACC, 0, 0, 0, 0, 0, 0, 0, E_FRZ));
    step(mk("tmo_rel",   F_ACC, 0, 0, 0, 0, 0, 0, 0, E_RUN | REQ));
    step(mk("tmo_err",   7'h00, 0, 0, 0, 0, 0, 0, 0, E_RUN | ERR));
    step(mk("tmo_lu",    F_LD,  0, 4, 0, 0, 4, 0, 0, E_LU | ERR));
    step(mk("tmo_stick", F_MRW, 0, 0, 2, 0, 0, 2, 0, E_RUN | FA_MEM | ERR));

    // Reset in the middle of a DM wait.
    step(mk("rstw_c1", F_ACC,         0, 0, 0, 0, 0, 0, 0, E_FRZ | ERR));
    step(mk("rstw_c2", F_ACC,         0, 0, 0, 0, 0, 0, 0, E_FRZ | ERR));
    step(mk("rstw_rst", F_RST | F_ACC, 0, 0, 0, 0, 0, 0, 0, E_RST | ERR));
    step(mk("rstw_run", 7'h00,        0, 0, 0, 0, 0, 0, 0, E_RUN));
    step(mk("rstw_run2", 7'h00,       0, 0, 0, 0, 0, 0, 0, E_RUN));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
